// File: rtl/dm_rambus_pkg.sv
// Shared types and constants for the two-port RamBus arbiter.
package dm_rambus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } rambusState_t;

  localparam int RAMBUS_ADDR_W = 14;
  localparam int RAMBUS_DATA_W = 32;
  localparam logic [31:0] RAMBUS_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/dm_rambus_arbiter.sv
// Round-robin arbiter sharing one register-bank target between two APB-style RamBus requesters.
// Optional WAIT-state timeout is enabled by defining RAMBUS_ARB_TIMEOUT_EN.
module dm_rambus_arbiter
  import dm_rambus_pkg::*;
#(
  parameter int ADDR_W      = RAMBUS_ADDR_W,
  parameter int DATA_W      = RAMBUS_DATA_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] RamBusAddress0,
  input  logic [ADDR_W-1:0] RamBusAddress1,
  input  logic [DATA_W-1:0] RamBusDataIn0,
  input  logic [DATA_W-1:0] RamBusDataIn1,
  input  logic              RamBusnCs0,
  input  logic              RamBusnCs1,
  input  logic              RamBusLatch0,
  input  logic              RamBusLatch1,
  input  logic              RamBusWrnRd0,
  input  logic              RamBusWrnRd1,
  output logic [DATA_W-1:0] RamBusDataOut0,
  output logic [DATA_W-1:0] RamBusDataOut1,
  output logic              RamBusAck0,
  output logic              RamBusAck1,
  output logic [ADDR_W-1:0] TgtAddress,
  output logic [DATA_W-1:0] TgtDataIn,
  output logic              TgtWrnRd,
  output logic              TgtStb,
  input  logic [DATA_W-1:0] TgtDataOut,
  input  logic              TgtAck,
  output logic              Grant,
  output logic              TimeoutErr
);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : gTimeoutRange
    $error("TIMEOUT_CYC out of range 1..65535");
  end

  rambusState_t stateReg, stateNext;
  logic              grantReg;
  logic [ADDR_W-1:0] tgtAddressReg;
  logic [DATA_W-1:0] tgtDataInReg;
  logic              tgtWrnRdReg;
  logic [DATA_W-1:0] dataOut0Reg, dataOut1Reg;

  logic              req0, req1;
  logic              loadReq, selPort, captureRd, timeoutHit;
  logic [DATA_W-1:0] rdData;

  // APB select is active high despite the nCs name
  assign req0 = RamBusnCs0 & RamBusLatch0;
  assign req1 = RamBusnCs1 & RamBusLatch1;

`ifdef RAMBUS_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] timeoutCntReg;
  logic        timeoutErrReg;
`endif

  always_comb begin
    stateNext  = stateReg;
    loadReq    = 1'b0;
    selPort    = grantReg;
    captureRd  = 1'b0;
    timeoutHit = 1'b0;
    rdData     = TgtDataOut;
    case (stateReg)
      IDLE: begin
        if (req0 | req1) begin
          loadReq   = 1'b1;
          selPort   = (req0 & req1) ? ~grantReg : req1;
          stateNext = ISSUE;
        end
      end
      // TgtAck during the strobe cycle is deliberately not looked at
      ISSUE: stateNext = WAIT;
      WAIT: begin
        if (TgtAck) begin
          captureRd = ~tgtWrnRdReg;
          stateNext = DONE;
        end
`ifdef RAMBUS_ARB_TIMEOUT_EN
        else if (timeoutCntReg == TIMEOUT_LAST) begin
          timeoutHit = 1'b1;
          captureRd  = ~tgtWrnRdReg;
          rdData     = DATA_W'(RAMBUS_TIMEOUT_DATA);
          stateNext  = DONE;
        end
`endif
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg      <= IDLE;
      grantReg      <= 1'b0;
      tgtAddressReg <= '0;
      tgtDataInReg  <= '0;
      tgtWrnRdReg   <= 1'b0;
      dataOut0Reg   <= '0;
      dataOut1Reg   <= '0;
    end else begin
      stateReg <= stateNext;
      if (loadReq) begin
        grantReg      <= selPort;
        tgtAddressReg <= selPort ? RamBusAddress1 : RamBusAddress0;
        tgtDataInReg  <= selPort ? RamBusDataIn1  : RamBusDataIn0;
        tgtWrnRdReg   <= selPort ? RamBusWrnRd1   : RamBusWrnRd0;
      end
      if (captureRd && !grantReg) dataOut0Reg <= rdData;
      if (captureRd &&  grantReg) dataOut1Reg <= rdData;
    end
  end

`ifdef RAMBUS_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeoutCntReg <= '0;
      timeoutErrReg <= 1'b0;
    end else begin
      if (stateReg == ISSUE)     timeoutCntReg <= '0;
      else if (stateReg == WAIT) timeoutCntReg <= timeoutCntReg + 16'd1;
      if (timeoutHit)            timeoutErrReg <= 1'b1;
    end
  end
  assign TimeoutErr = timeoutErrReg;
`else
  assign TimeoutErr = 1'b0;
`endif

  assign TgtStb         = (stateReg == ISSUE);
  assign RamBusAck0     = (stateReg == DONE) && !grantReg;
  assign RamBusAck1     = (stateReg == DONE) &&  grantReg;
  assign TgtAddress     = tgtAddressReg;
  assign TgtDataIn      = tgtDataInReg;
  assign TgtWrnRd       = tgtWrnRdReg;
  assign Grant          = grantReg;
  assign RamBusDataOut0 = dataOut0Reg;
  assign RamBusDataOut1 = dataOut1Reg;

endmodule

// File: tb/tb_dm_rambus_arbiter.sv
// Directed self-checking bench for dm_rambus_arbiter; timeout steps run when RAMBUS_ARB_TIMEOUT_EN is defined.
module tb_dm_rambus_arbiter;

`ifdef RAMBUS_ARB_TIMEOUT_EN
  localparam int TO_CYC = 4;
`else
  localparam int TO_CYC = 255;
`endif
  // keep the slow-ack read inside the timeout window
  localparam int ACK_DLY = (TO_CYC > 5) ? 5 : TO_CYC - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] RamBusAddress0 = '0, RamBusAddress1 = '0;
  logic [31:0] RamBusDataIn0 = '0, RamBusDataIn1 = '0;
  logic        RamBusnCs0 = 1'b0, RamBusnCs1 = 1'b0;
  logic        RamBusLatch0 = 1'b0, RamBusLatch1 = 1'b0;
  logic        RamBusWrnRd0 = 1'b0, RamBusWrnRd1 = 1'b0;
  logic [31:0] RamBusDataOut0, RamBusDataOut1;
  logic        RamBusAck0, RamBusAck1;
  logic [13:0] TgtAddress;
  logic [31:0] TgtDataIn;
  logic        TgtWrnRd, TgtStb;
  logic [31:0] TgtDataOut = '0;
  logic        TgtAck = 1'b0;
  logic        Grant, TimeoutErr;

  int total = 0;
  int bad = 0;
  int stbCnt = 0, ack0Cnt = 0, ack1Cnt = 0;
  int stbSnap, ack0Snap, ack1Snap;

  dm_rambus_arbiter #(.ADDR_W(14), .DATA_W(32), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst),
    .RamBusAddress0(RamBusAddress0), .RamBusAddress1(RamBusAddress1),
    .RamBusDataIn0(RamBusDataIn0), .RamBusDataIn1(RamBusDataIn1),
    .RamBusnCs0(RamBusnCs0), .RamBusnCs1(RamBusnCs1),
    .RamBusLatch0(RamBusLatch0), .RamBusLatch1(RamBusLatch1),
    .RamBusWrnRd0(RamBusWrnRd0), .RamBusWrnRd1(RamBusWrnRd1),
    .RamBusDataOut0(RamBusDataOut0), .RamBusDataOut1(RamBusDataOut1),
    .RamBusAck0(RamBusAck0), .RamBusAck1(RamBusAck1),
    .TgtAddress(TgtAddress), .TgtDataIn(TgtDataIn), .TgtWrnRd(TgtWrnRd), .TgtStb(TgtStb),
    .TgtDataOut(TgtDataOut), .TgtAck(TgtAck),
    .Grant(Grant), .TimeoutErr(TimeoutErr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (TgtStb)     stbCnt++;
    if (RamBusAck0) ack0Cnt++;
    if (RamBusAck1) ack1Cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic req0(input logic on, input logic wr, input logic [13:0] a, input logic [31:0] d);
    RamBusnCs0 = on; RamBusLatch0 = on; RamBusWrnRd0 = wr; RamBusAddress0 = a; RamBusDataIn0 = d;
  endtask

  task automatic req1(input logic on, input logic wr, input logic [13:0] a, input logic [31:0] d);
    RamBusnCs1 = on; RamBusLatch1 = on; RamBusWrnRd1 = wr; RamBusAddress1 = a; RamBusDataIn1 = d;
  endtask

  initial begin
    // reset values
    tick(); tick();
    check("rst_stb", TgtStb, 0);
    check("rst_ack0", RamBusAck0, 0);
    check("rst_ack1", RamBusAck1, 0);
    check("rst_grant", Grant, 0);
    check("rst_toerr", TimeoutErr, 0);
    check("rst_addr", TgtAddress, 0);
    check("rst_dout0", RamBusDataOut0, 0);

    // port 0 write, request present when reset releases
    rst = 1'b0;
    req0(1, 1, 14'h0010, 32'h1234_5678);
    stbSnap = stbCnt; ack0Snap = ack0Cnt; ack1Snap = ack1Cnt;
    tick();
    $display("txn p0 write addr=0010 data=12345678");
    check("w0_issue_stb", TgtStb, 1);
    check("w0_issue_addr", TgtAddress, 14'h0010);
    check("w0_issue_data", TgtDataIn, 32'h1234_5678);
    check("w0_issue_wr", TgtWrnRd, 1);
    check("w0_issue_grant", Grant, 0);
    tick();
    check("w0_wait_stb", TgtStb, 0);
    check("w0_wait_ack0", RamBusAck0, 0);
    TgtAck = 1'b1;
    tick();
    check("w0_done_ack0", RamBusAck0, 1);
    check("w0_done_ack1", RamBusAck1, 0);
    check("w0_done_addr_hold", TgtAddress, 14'h0010);
    TgtAck = 1'b0;
    req0(0, 0, '0, '0);
    tick();
    check("w0_idle_ack0", RamBusAck0, 0);
    check("w0_stb_pulses", stbCnt - stbSnap, 1);
    check("w0_ack0_pulses", ack0Cnt - ack0Snap, 1);
    check("w0_ack1_pulses", ack1Cnt - ack1Snap, 0);
    check("w0_dout0_write", RamBusDataOut0, 0);

    // port 1 read, ack during the strobe cycle must be ignored, real ack after ACK_DLY wait cycles
    req1(1, 0, 14'h3FFF, 32'h0);
    tick();
    $display("txn p1 read addr=3fff");
    check("r1_issue_grant", Grant, 1);
    check("r1_issue_addr", TgtAddress, 14'h3FFF);
    check("r1_issue_wr", TgtWrnRd, 0);
    check("r1_issue_stb", TgtStb, 1);
    TgtAck = 1'b1; TgtDataOut = 32'h1111_1111;
    tick();
    TgtAck = 1'b0; TgtDataOut = 32'h0;
    for (int i = 1; i < ACK_DLY; i++) begin
      check("r1_wait_ack1", RamBusAck1, 0);
      tick();
    end
    TgtAck = 1'b1; TgtDataOut = 32'hCAFE_F00D;
    tick();
    check("r1_done_ack1", RamBusAck1, 1);
    check("r1_done_dout1", RamBusDataOut1, 32'hCAFE_F00D);
    check("r1_done_dout0", RamBusDataOut0, 0);
    TgtAck = 1'b0; TgtDataOut = 32'h0;
    req1(0, 0, '0, '0);
    tick();
    check("r1_hold_dout1", RamBusDataOut1, 32'hCAFE_F00D);

    // both ports request directly after reset: port 1 first, then port 0
    rst = 1'b1; #1; rst = 1'b0;
    req0(1, 0, 14'h0001, 32'h0);
    req1(1, 1, 14'h0002, 32'hA5A5_A5A5);
    ack0Snap = ack0Cnt; ack1Snap = ack1Cnt;
    tick();
    $display("txn both: p1 write addr=0002 then p0 read addr=0001");
    check("rr_first_grant", Grant, 1);
    check("rr_first_addr", TgtAddress, 14'h0002);
    tick();
    TgtAck = 1'b1; TgtDataOut = 32'h55AA_55AA;
    tick();
    check("rr_first_ack1", RamBusAck1, 1);
    check("rr_first_ack0", RamBusAck0, 0);
    TgtAck = 1'b0;
    req1(0, 0, '0, '0);
    tick();
    check("rr_gap_ack1", RamBusAck1, 0);
    check("rr_gap_stb", TgtStb, 0);
    tick();
    check("rr_second_grant", Grant, 0);
    check("rr_second_addr", TgtAddress, 14'h0001);
    check("rr_second_stb", TgtStb, 1);
    tick();
    TgtAck = 1'b1; TgtDataOut = 32'h0BAD_F00D;
    tick();
    check("rr_second_ack0", RamBusAck0, 1);
    check("rr_second_dout0", RamBusDataOut0, 32'h0BAD_F00D);
    check("rr_dout1_write", RamBusDataOut1, 0);
    TgtAck = 1'b0; TgtDataOut = 32'h0;
    req0(0, 0, '0, '0);
    tick();
    check("rr_ack0_pulses", ack0Cnt - ack0Snap, 1);
    check("rr_ack1_pulses", ack1Cnt - ack1Snap, 1);

    // reset during WAIT of a port 0 read
    req0(1, 0, 14'h0123, 32'h0);
    tick(); tick(); tick();
    $display("txn p0 read addr=0123 aborted by reset");
    check("ar_pre_addr", TgtAddress, 14'h0123);
    #2 rst = 1'b1;
    #1;
    check("ar_addr", TgtAddress, 0);
    check("ar_dout0", RamBusDataOut0, 0);
    check("ar_ack0", RamBusAck0, 0);
    check("ar_stb", TgtStb, 0);
    check("ar_grant", Grant, 0);
    req0(0, 0, '0, '0);
    tick();
    rst = 1'b0;
    TgtAck = 1'b1; TgtDataOut = 32'h7777_7777;
    stbSnap = stbCnt; ack0Snap = ack0Cnt; ack1Snap = ack1Cnt;
    tick(); tick();
    TgtAck = 1'b0; TgtDataOut = 32'h0;
    check("ar_late_ack0", ack0Cnt - ack0Snap, 0);
    check("ar_late_stb", stbCnt - stbSnap, 0);
    check("ar_late_dout0", RamBusDataOut0, 0);
    req1(1, 0, 14'h0ABC, 32'h0);
    tick();
    $display("txn p1 read addr=0abc after reset");
    check("ar_next_grant", Grant, 1);
    check("ar_next_addr", TgtAddress, 14'h0ABC);
    tick();
    TgtAck = 1'b1; TgtDataOut = 32'h1357_2468;
    tick();
    check("ar_next_ack1", RamBusAck1, 1);
    check("ar_next_dout1", RamBusDataOut1, 32'h1357_2468);
    TgtAck = 1'b0; TgtDataOut = 32'h0;
    req1(0, 0, '0, '0);
    tick();

`ifdef RAMBUS_ARB_TIMEOUT_EN
    // port 0 read that never gets TgtAck
    req0(1, 0, 14'h0020, 32'h0);
    tick();
    $display("txn p0 read addr=0020 timeout");
    tick(); tick(); tick(); tick();
    check("to_wait4_ack0", RamBusAck0, 0);
    check("to_wait4_err", TimeoutErr, 0);
    tick();
    check("to_done_ack0", RamBusAck0, 1);
    check("to_done_dout0", RamBusDataOut0, 32'hDEAD_BEEF);
    check("to_done_err", TimeoutErr, 1);
    req0(0, 0, '0, '0);
    tick(); tick(); tick();
    check("to_hold_err", TimeoutErr, 1);
    check("to_hold_dout0", RamBusDataOut0, 32'hDEAD_BEEF);
    rst = 1'b1; #1;
    check("to_rst_err", TimeoutErr, 0);
    rst = 1'b0;
`else
    check("no_timeout_err", TimeoutErr, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_rambus_arbiter.md
DM_RAMBUS_ARBITER -- requirements
Module: dm_rambus_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: ports clk and rst.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- ADDR_W, 14, requester and target address width.
- DATA_W, 32, data width.
- TIMEOUT_CYC, 255, maximum wait for TgtAck in cycles; range 1..65535.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, fabric clock (CCC GL0).
- rst, in, 1, asynchronous active-high reset.
- RamBusAddress0 / RamBusAddress1, in, ADDR_W, requester address.
- RamBusDataIn0 / RamBusDataIn1, in, DATA_W, requester write data.
- RamBusnCs0 / RamBusnCs1, in, 1, requester select; APB PSEL, active high despite the name.
- RamBusLatch0 / RamBusLatch1, in, 1, access phase; APB PENABLE.
- RamBusWrnRd0 / RamBusWrnRd1, in, 1, 1 = write, 0 = read.
- RamBusDataOut0 / RamBusDataOut1, out, DATA_W, read data to requester.
- RamBusAck0 / RamBusAck1, out, 1, PREADY to requester.
- TgtAddress, out, ADDR_W, shared register-bank address.
- TgtDataIn, out, DATA_W, shared write data.
- TgtWrnRd, out, 1, shared direction.
- TgtStb, out, 1, one-cycle transaction strobe.
- TgtDataOut, in, DATA_W, register-bank read data.
- TgtAck, in, 1, register-bank completion.
- Grant, out, 1, port currently or last served.
- TimeoutErr, out, 1, sticky timeout flag.

Function
REQ-004 A request on port n SHALL be defined as RamBusnCsn & RamBusLatchn, sampled on the rising edge of clk.
REQ-005 The FSM SHALL have four states: IDLE, ISSUE, WAIT, DONE.
REQ-006 IDLE SHALL do the following:
- One port requesting: latch that port's Address, DataIn and WrnRd; set Grant to that port; go to ISSUE.
- Both ports requesting: grant the port other than Grant (round-robin); Grant SHALL be 0 after reset.
- No request: remain in IDLE.
REQ-007 ISSUE SHALL assert TgtStb for exactly one cycle with the latched Tgt* values, then go to WAIT.
REQ-008 TgtAddress, TgtDataIn and TgtWrnRd SHALL stay stable from ISSUE until the next ISSUE.
REQ-009 WAIT SHALL capture TgtDataOut into RamBusDataOut of the granted port on the first cycle TgtAck=1, then go to DONE.
- TgtAck asserted in the same cycle as TgtStb SHALL be ignored.
REQ-010 DONE SHALL assert RamBusAck of the granted port for exactly one cycle, then go to IDLE.
REQ-011 Minimum latency SHALL be 3 cycles from request detection to Ack when TgtAck is returned on the first WAIT cycle.
REQ-012 RamBusAck of the non-granted port SHALL be 0 at all times; its request SHALL be held pending without loss.
REQ-013 RamBusDataOutn SHALL hold its last captured value until that port's next completed read.
- Writes SHALL leave RamBusDataOutn unchanged.
REQ-014 A request that deasserts before being granted SHALL be dropped silently.
REQ-015 A request that deasserts after being granted SHALL still complete the target transaction, and Ack SHALL still pulse.
REQ-016 Back-to-back requests SHALL alternate between ports with one IDLE cycle between transactions.

Reset
REQ-017 Reset SHALL take effect asynchronously, including mid-transaction, with these values:
- FSM = IDLE.
- TgtStb = 0; both Acks = 0.
- Grant = 0; TimeoutErr = 0.
- All data outputs = 0; Tgt* outputs = 0; timeout counter = 0.
REQ-018 After rst deasserts, the first request SHALL be accepted on the first clk edge.

Configuration
REQ-019 With RAMBUS_ARB_TIMEOUT_EN defined:
- WAIT SHALL count cycles.
- If TgtAck has not arrived after TIMEOUT_CYC cycles, the FSM SHALL load 32'hDEAD_BEEF into RamBusDataOut of the granted port (reads only), set TimeoutErr, and go to DONE.
- TimeoutErr SHALL clear only on rst.
REQ-020 Without RAMBUS_ARB_TIMEOUT_EN, WAIT SHALL wait indefinitely, TimeoutErr SHALL be tied to 0, and no counter logic SHALL be present.

Structure
REQ-021 Package dm_rambus_pkg SHALL hold the following, and no other block-specific types:
- the FSM state enum;
- RAMBUS_ADDR_W = 14 and RAMBUS_DATA_W = 32;
- RAMBUS_TIMEOUT_DATA = 32'hDEAD_BEEF.
REQ-022 The block SHALL be a single module with no sub-modules.

Verification
REQ-023 Port 0 writes Address 0x0010, DataIn 0x12345678, TgtAck returned on the first WAIT cycle:
- TgtStb pulses once with those values.
- RamBusAck0 pulses 3 cycles after request detection.
- RamBusAck1 stays 0.
REQ-024 Port 1 reads Address 0x3FFF while the model returns 0xCAFEF00D after 5 cycles:
- RamBusDataOut1 = 0xCAFEF00D when RamBusAck1 pulses.
- RamBusDataOut0 is unchanged.
REQ-025 Both ports request on the same edge directly after reset:
- Port 1 is served first, then port 0.
- Grant sequence is 1, 0; each Ack pulses exactly once.
REQ-026 Assert rst during WAIT of a port 0 read:
- All outputs return to reset values immediately.
- A late TgtAck produces no Ack.
- The next request completes normally.
REQ-027 With RAMBUS_ARB_TIMEOUT_EN and TIMEOUT_CYC = 4, a port 0 read that never receives TgtAck:
- RamBusAck0 pulses after the timeout expires.
- RamBusDataOut0 = 0xDEADBEEF and TimeoutErr = 1, held until rst.
